reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the core's register file: NUM_RD combinational read ports, one write port, write-to-read bypass, asynchronous clear.
- Adds a per-register pending (scoreboard) bit: set when an instruction writing that register issues, cleared by its writeback. The decode stage uses it to stall on RAW hazards.
- Sits between decode (read and issue ports) and writeback (write port) of the pipelined core.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never pending

Ports:
- clk  in  1  core clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- wen  in  1  writeback valid
- waddr  in  ADDR_WIDTH  writeback register address
- wdata  in  DATA_WIDTH  writeback data
- raddr  in  NUM_RD*ADDR_WIDTH  read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NUM_RD*DATA_WIDTH  read data, packed the same way
- rbusy  out  NUM_RD  1 = port i register has an outstanding producer
- iss_valid  in  1  instruction issued that will write iss_addr
- iss_addr  in  ADDR_WIDTH  destination of the issuing instruction
- pend_vec  out  DEPTH  current pending bits, bit n = register n
- wb_err  out  1  registered, sticky: writeback hit a non-pending register

Behaviour:
- Reset (async, rst=1):
  - all registers, pending bits and wb_err clear to 0 immediately, without waiting for a clock edge;
  - while rst=1, rdata=0, rbusy=0 and pend_vec=0; all inputs are ignored;
  - if rst asserts mid-operation, pending state is discarded, with no recovery.
- Write: on posedge with wen=1, reg[waddr] <= wdata. If ZERO_REG=1 and waddr=0, the write is dropped.
- Read: combinational, zero latency.
  - If wen=1 and waddr equals raddr[i], and the address is not zero with ZERO_REG=1, rdata[i]=wdata (bypass). Otherwise rdata[i]=reg[raddr[i]].
  - With ZERO_REG=1, raddr[i]=0 always returns 0.
- Pending update at posedge, for each register n:
  - set when iss_valid and iss_addr==n;
  - else cleared when wen and waddr==n;
  - else held.
  - Issue and writeback to the same register in the same cycle: set wins. The writeback still updates the data.
  - ZERO_REG=1: bit 0 is never set.
- rbusy[i] = pend[raddr[i]] AND NOT (wen AND waddr==raddr[i]).
  - A same-cycle writeback resolves the hazard through the bypass.
  - A same-cycle issue does not affect rbusy until the next cycle.
- wb_err is set at posedge when wen=1, the address is not register 0 with ZERO_REG=1, and pend[waddr]=0. It stays 1 until reset. The data write still happens.
- Re-issue to an already pending register keeps the bit set. Only one producer per register is tracked.
- Timing: no added latency on any path. The write-to-read bypass is the critical path and must be a single mux level per port.

Decomposition:
- Shared package (core defines):
  - default DATA_WIDTH/ADDR_WIDTH constants, reused from the existing register and address width defines;
  - ZERO_REG default.
- Natural sub-module: reg_file_rd_port, one instance per read port via generate. Contents: address decode, bypass compare, zero-register mask, rbusy logic.
- The storage array and pending vector stay in the top module.

Test Plan:
- Reset then read: assert rst=1 mid-run after writing r5=0xDEADBEEF, no clock edge. Required: rdata=0 and pend_vec=0 immediately. After release, reading r5 returns 0.
- Bypass: wen=1, waddr=7, wdata=0x12345678, raddr0=7 in the same cycle. Required: rdata0=0x12345678 before the edge, and reg[7] holds it after the edge.
- Zero register: write 0xFFFFFFFF to r0, then iss_valid with iss_addr=0. Required: rdata=0, pend_vec[0]=0, wb_err stays 0.
- Scoreboard: issue r3 in cycle 1; read r3 in cycle 2 gives rbusy=1; writeback r3=0xA5 in cycle 3. Required: in cycle 3, rbusy=0 and rdata=0xA5 via bypass; in cycle 4, pend_vec[3]=0.
- Simultaneous issue and writeback to r9, with r9 pending from an earlier issue. Required: pend_vec[9] stays 1, reg[9] holds the new data, and rbusy for r9 is 0 in that cycle and 1 in the next.
- Writeback r12=0x1 with r12 not pending. Required: wb_err=1 from the next cycle, sticky until rst; reg[12]=0x1. With NUM_RD=4, all four ports read distinct registers correctly in the same cycle.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Core-wide register file defaults shared by the
// register file and its read-port slices.
package reg_file_sb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam bit ZERO_REG_DEF = 1'b1;

  localparam int unsigned NUM_RD_MIN = 1;
  localparam int unsigned NUM_RD_MAX = 4;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: decode, bypass,
// zero-register mask and RAW busy flag.
module reg_file_rd_port
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_AW,
  parameter bit ZERO_REG   = ZERO_REG_DEF,
  localparam int DEPTH     = 2**ADDR_WIDTH
) (
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  wr_ok,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] regs [DEPTH],
  input  logic [DEPTH-1:0]      pend,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rbusy
);

  logic rzero;
  logic hit;

  assign rzero = ZERO_REG && (raddr == '0);

  // wr_ok already drops r0 writes, so r0 never bypasses
  assign hit = wr_ok && (waddr == raddr);

  always_comb begin
    rdata = regs[raddr];
    if (hit)
      rdata = wdata;
    if (rst || rzero)
      rdata = '0;
  end

  assign rbusy = !rst && pend[raddr] && !hit;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with write bypass and a per-register
// pending scoreboard for decode-stage RAW stalls.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_AW,
  parameter int NUM_RD     = 2,
  parameter bit ZERO_REG   = ZERO_REG_DEF,
  localparam int DEPTH     = 2**ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  output logic [DEPTH-1:0]             pend_vec,
  output logic                         wb_err
);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pend;
  logic [DEPTH-1:0]      pend_nxt;

  logic wr_ok;
  logic iss_ok;

  assign wr_ok  = wen && !(ZERO_REG && (waddr == '0));
  assign iss_ok = iss_valid && !(ZERO_REG && (iss_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < DEPTH; n++)
        regs[n] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Issue is applied after writeback so a same-cycle set wins
  always_comb begin
    pend_nxt = pend;
    if (wr_ok)
      pend_nxt[waddr] = 1'b0;
    if (iss_ok)
      pend_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= '0;
      wb_err <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (wr_ok && !pend[waddr])
        wb_err <= 1'b1;
    end
  end

  assign pend_vec = pend;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    reg_file_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_rd (
      .rst   (rst),
      .raddr (raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .wr_ok (wr_ok),
      .waddr (waddr),
      .wdata (wdata),
      .regs  (regs),
      .pend  (pend),
      .rdata (rdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .rbusy (rbusy[i])
    );
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb with
// four read ports and the zero register enabled.
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int DP = 32;

  localparam int K_RD  = 0;
  localparam int K_BSY = 1;
  localparam int K_PND = 2;
  localparam int K_ERR = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            wen;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]   rbusy;
  logic            iss_valid;
  logic [AW-1:0]   iss_addr;
  logic [DP-1:0]   pend_vec;
  logic            wb_err;

  reg_file_sb #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_RD     (NR),
    .ZERO_REG   (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .pend_vec  (pend_vec),
    .wb_err    (wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          port;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] observe(int kind, int port);
    case (kind)
      K_RD:    return rdata[port*DW +: DW];
      K_BSY:   return {31'b0, rbusy[port]};
      K_PND:   return pend_vec;
      default: return {31'b0, wb_err};
    endcase
  endfunction

  task automatic push(int kind, int port, logic [31:0] e, string tag);
    exp_t x;
    x.kind = kind;
    x.port = port;
    x.exp  = e;
    x.tag  = tag;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [31:0] o;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = observe(x.kind, x.port);
      checks++;
      assert (o === x.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(int p, logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    wen       = 1'b0;
    iss_valid = 1'b0;
  endtask

  task automatic wr(logic [AW-1:0] a, logic [DW-1:0] d);
    wen   = 1'b1;
    waddr = a;
    wdata = d;
  endtask

  task automatic iss(logic [AW-1:0] a);
    iss_valid = 1'b1;
    iss_addr  = a;
  endtask

  initial begin
    rst = 1'b1;
    wen = 1'b0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
    iss_valid = 1'b0;
    iss_addr = '0;

    // inputs ignored while in reset
    @(posedge clk);
    #1;
    wr(5, 32'h55);
    iss(5);
    rd(0, 5);
    push(K_RD, 0, 32'h0, "rst_rdata_bypass");
    push(K_BSY, 0, 32'h0, "rst_rbusy");
    push(K_PND, 0, 32'h0, "rst_pend");
    push(K_ERR, 0, 32'h0, "rst_wb_err");
    cyc();
    push(K_RD, 0, 32'h0, "rst_rdata_hold");
    push(K_PND, 0, 32'h0, "rst_pend_hold");
    cyc();
    idle();
    rst = 1'b0;

    // write r5, leave r6 pending, then async reset
    iss(5);
    rd(0, 5);
    push(K_BSY, 0, 32'h0, "iss_same_cycle_busy");
    cyc();
    idle();
    wr(5, 32'hDEADBEEF);
    iss(6);
    rd(1, 6);
    push(K_RD, 0, 32'hDEADBEEF, "r5_bypass");
    push(K_BSY, 0, 32'h0, "r5_busy_bypass");
    push(K_BSY, 1, 32'h0, "r6_busy_issue");
    cyc();
    idle();
    push(K_RD, 0, 32'hDEADBEEF, "r5_read");
    push(K_PND, 0, 32'h40, "r6_pend");
    push(K_BSY, 1, 32'h1, "r6_busy");
    push(K_ERR, 0, 32'h0, "no_err_r5");
    cyc();
    rst = 1'b1;
    #2;
    push(K_RD, 0, 32'h0, "async_rst_rdata");
    push(K_BSY, 1, 32'h0, "async_rst_rbusy");
    push(K_PND, 0, 32'h0, "async_rst_pend");
    drain();
    cyc();
    rst = 1'b0;
    rd(0, 5);
    push(K_RD, 0, 32'h0, "r5_after_rst");
    push(K_PND, 0, 32'h0, "pend_after_rst");
    cyc();

    // bypass on r7
    iss(7);
    cyc();
    idle();
    wr(7, 32'h12345678);
    rd(0, 7);
    push(K_RD, 0, 32'h12345678, "r7_bypass");
    push(K_BSY, 0, 32'h0, "r7_busy_bypass");
    cyc();
    idle();
    push(K_RD, 0, 32'h12345678, "r7_stored");
    push(K_PND, 0, 32'h0, "r7_pend_clr");
    push(K_ERR, 0, 32'h0, "r7_no_err");
    cyc();

    // zero register
    wr(0, 32'hFFFFFFFF);
    iss(0);
    rd(0, 0);
    rd(1, 0);
    push(K_RD, 0, 32'h0, "r0_no_bypass0");
    push(K_RD, 1, 32'h0, "r0_no_bypass1");
    push(K_BSY, 0, 32'h0, "r0_busy");
    cyc();
    idle();
    push(K_RD, 0, 32'h0, "r0_read");
    push(K_PND, 0, 32'h0, "r0_pend");
    push(K_ERR, 0, 32'h0, "r0_no_err");
    cyc();

    // scoreboard on r3
    iss(3);
    rd(0, 3);
    push(K_BSY, 0, 32'h0, "r3_c1_busy");
    cyc();
    idle();
    push(K_BSY, 0, 32'h1, "r3_c2_busy");
    push(K_PND, 0, 32'h8, "r3_c2_pend");
    cyc();
    wr(3, 32'hA5);
    push(K_BSY, 0, 32'h0, "r3_c3_busy");
    push(K_RD, 0, 32'hA5, "r3_c3_bypass");
    cyc();
    idle();
    push(K_PND, 0, 32'h0, "r3_c4_pend");
    push(K_RD, 0, 32'hA5, "r3_c4_read");
    push(K_BSY, 0, 32'h0, "r3_c4_busy");
    push(K_ERR, 0, 32'h0, "r3_no_err");
    cyc();

    // issue and writeback to r9 together
    iss(9);
    cyc();
    wr(9, 32'h99);
    rd(0, 9);
    push(K_BSY, 0, 32'h0, "r9_same_busy");
    push(K_RD, 0, 32'h99, "r9_same_bypass");
    cyc();
    idle();
    push(K_PND, 0, 32'h200, "r9_pend_kept");
    push(K_BSY, 0, 32'h1, "r9_next_busy");
    push(K_RD, 0, 32'h99, "r9_stored");
    push(K_ERR, 0, 32'h0, "r9_no_err");
    cyc();
    wr(9, 32'h99);
    push(K_BSY, 0, 32'h0, "r9_wb_busy");
    cyc();
    idle();
    push(K_PND, 0, 32'h0, "r9_pend_clr");
    push(K_ERR, 0, 32'h0, "r9_wb_no_err");
    cyc();

    // writeback to non-pending r12
    wr(12, 32'h1);
    push(K_ERR, 0, 32'h0, "r12_err_not_yet");
    cyc();
    idle();
    rd(0, 7);
    rd(1, 3);
    rd(2, 9);
    rd(3, 12);
    push(K_ERR, 0, 32'h1, "r12_err_set");
    push(K_RD, 0, 32'h12345678, "quad_r7");
    push(K_RD, 1, 32'hA5, "quad_r3");
    push(K_RD, 2, 32'h99, "quad_r9");
    push(K_RD, 3, 32'h1, "quad_r12");
    push(K_PND, 0, 32'h0, "quad_pend");
    cyc();
    push(K_ERR, 0, 32'h1, "r12_err_sticky");
    cyc();
    rst = 1'b1;
    #2;
    push(K_ERR, 0, 32'h0, "err_rst_clear");
    drain();
    cyc();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
